// File: rtl/divtest_ctrl.sv
// Control FSM for the 16-bit divide/primality datapath: trial division of n by d=2.. via repeated subtraction.
// Optional cycle-count output enabled by defining DIVTEST_CYCCNT_EN.
module divtest_ctrl #(
  parameter int unsigned MAX_CYCLES = 16'hFFFF,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       s,
  output logic             remld,
  output logic             divld,
  output logic             resld,
  output logic             nbuf,
  output logic             rembuf,
  output logic [1:0]       zc,
  output logic [1:0]       sc,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef DIVTEST_CYCCNT_EN
  ,
  output logic [CNT_W-1:0] cycles
`endif
);

  typedef enum logic [3:0] {
    IDLE, INIT_DIV, CHK_DIV, INIT_REM, SUB, INC_DIV, RES1, RES0, DONE
  } state_t;

  typedef struct packed {
    logic       remld;
    logic       divld;
    logic       resld;
    logic       nbuf;
    logic       rembuf;
    logic [1:0] zc;
    logic [1:0] sc;
    logic       busy;
    logic       done;
  } ctl_t;

  localparam logic [CNT_W-1:0] WD_LIM = CNT_W'(MAX_CYCLES);

  state_t           state_q, state_d;
  ctl_t             ctl_q;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_busy, wd_hit, sub_go;

  function automatic ctl_t decode(input state_t st);
    ctl_t c;
    c = '0;
    case (st)
      INIT_DIV: begin c.zc = 2'b11; c.sc = 2'b10; c.divld = 1'b1; c.busy = 1'b1; end
      CHK_DIV:  begin c.nbuf = 1'b1; c.zc = 2'b01; c.busy = 1'b1; end
      INIT_REM: begin c.nbuf = 1'b1; c.zc = 2'b00; c.remld = 1'b1; c.busy = 1'b1; end
      SUB:      begin c.rembuf = 1'b1; c.zc = 2'b01; c.busy = 1'b1; end
      INC_DIV:  begin c.zc = 2'b10; c.divld = 1'b1; c.busy = 1'b1; end
      RES1:     begin c.zc = 2'b11; c.sc = 2'b01; c.resld = 1'b1; c.busy = 1'b1; end
      RES0:     begin c.zc = 2'b11; c.sc = 2'b00; c.resld = 1'b1; c.busy = 1'b1; end
      DONE:     c.done = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    in_busy = state_q inside {INIT_DIV, CHK_DIV, INIT_REM, SUB, INC_DIV, RES1, RES0};
    wd_hit  = in_busy && (cnt_q == WD_LIM);
    if (in_busy) cnt_d = cnt_q + 1'b1;
    case (state_q)
      IDLE: if (start) begin
        state_d = INIT_DIV;
        err_d   = 1'b0;
        cnt_d   = '0;
      end
      INIT_DIV: state_d = CHK_DIV;
      CHK_DIV: begin
        if (s[0])      state_d = RES1;
        else if (s[1]) state_d = RES0;
        else           state_d = INIT_REM;
      end
      INIT_REM: state_d = SUB;
      SUB: begin
        if (s[0])      state_d = RES0;
        else if (s[1]) state_d = INC_DIV;
        else           state_d = SUB;
      end
      INC_DIV:    state_d = CHK_DIV;
      RES1, RES0: state_d = DONE;
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
    if (wd_hit) begin
      state_d = RES0;
      err_d   = 1'b1;
    end
  end

  // Outputs are registered from the next state so they stay a pure function of state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ctl_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= decode(state_d);
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // rem is reloaded in SUB only while the subtraction stays positive.
  assign sub_go = (state_q == SUB) && (s == 2'b00) && !wd_hit;

  assign remld  = ctl_q.remld | sub_go;
  assign divld  = ctl_q.divld;
  assign resld  = ctl_q.resld;
  assign nbuf   = ctl_q.nbuf;
  assign rembuf = ctl_q.rembuf;
  assign zc     = ctl_q.zc;
  assign sc     = ctl_q.sc;
  assign busy   = ctl_q.busy;
  assign done   = ctl_q.done;
  assign err    = err_q;

`ifdef DIVTEST_CYCCNT_EN
  logic [CNT_W-1:0] cycles_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cycles_q <= '0;
    else if (state_d == DONE) cycles_q <= cnt_d;
  end

  assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_divtest_ctrl.sv
// Bench for divtest_ctrl: two controllers (default watchdog and MAX_CYCLES=8) each closed around a datapath model,
// results compared against a trial-division reference computed arithmetically.
module tb_divtest_ctrl;

  localparam int unsigned MAXA = 16'hFFFF;
  localparam int unsigned MAXB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       start_a = 1'b0, start_b = 1'b0;
  logic [1:0] s_a, s_b;
  logic       remld_a, divld_a, resld_a, nbuf_a, rembuf_a, busy_a, done_a, err_a;
  logic       remld_b, divld_b, resld_b, nbuf_b, rembuf_b, busy_b, done_b, err_b;
  logic [1:0] zc_a, sc_a, zc_b, sc_b;
`ifdef DIVTEST_CYCCNT_EN
  logic [15:0] cyc_a, cyc_b;
`endif

  divtest_ctrl u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .s(s_a),
    .remld(remld_a), .divld(divld_a), .resld(resld_a), .nbuf(nbuf_a), .rembuf(rembuf_a),
    .zc(zc_a), .sc(sc_a), .busy(busy_a), .done(done_a), .err(err_a)
`ifdef DIVTEST_CYCCNT_EN
    , .cycles(cyc_a)
`endif
  );

  divtest_ctrl #(.MAX_CYCLES(MAXB)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .s(s_b),
    .remld(remld_b), .divld(divld_b), .resld(resld_b), .nbuf(nbuf_b), .rembuf(rembuf_b),
    .zc(zc_b), .sc(sc_b), .busy(busy_b), .done(done_b), .err(err_b)
`ifdef DIVTEST_CYCCNT_EN
    , .cycles(cyc_b)
`endif
  );

  // Datapath models
  logic [15:0] n_a = '0, rem_a = '0, div_a = '0, n_b = '0, rem_b = '0, div_b = '0;
  logic        res_a = 1'b0, res_b = 1'b0;
  logic [15:0] z_a, z_b;

  function automatic logic [15:0] alu(input logic [1:0] op, input logic [1:0] k, input logic nb, input logic rb,
                                      input logic [15:0] n, input logic [15:0] rem, input logic [15:0] dv);
    logic [15:0] x;
    x = nb ? n : (rb ? rem : 16'd0);
    case (op)
      2'b00:   return x;
      2'b01:   return x - dv;
      2'b10:   return dv + 16'd1;
      default: return {14'd0, k};
    endcase
  endfunction

  always_comb begin
    z_a = alu(zc_a, sc_a, nbuf_a, rembuf_a, n_a, rem_a, div_a);
    z_b = alu(zc_b, sc_b, nbuf_b, rembuf_b, n_b, rem_b, div_b);
    s_a = {z_a[15], z_a == 16'd0};
    s_b = {z_b[15], z_b == 16'd0};
  end

  always @(posedge clk) begin
    if (remld_a) rem_a <= z_a;
    if (divld_a) div_a <= z_a;
    if (resld_a) res_a <= z_a[0];
    if (remld_b) rem_b <= z_b;
    if (divld_b) div_b <= z_b;
    if (resld_b) res_b <= z_b[0];
  end

  logic [1:0] done_v, busy_v, err_v, nbuf_v, rembuf_v, res_v;
  assign done_v   = {done_b, done_a};
  assign busy_v   = {busy_b, busy_a};
  assign err_v    = {err_b, err_a};
  assign nbuf_v   = {nbuf_b, nbuf_a};
  assign rembuf_v = {rembuf_b, rembuf_a};
  assign res_v    = {res_b, res_a};

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Busy-cycle count (INIT_DIV through the result write) of an unhindered run, and primality.
  function automatic int unsigned ref_busy(input int unsigned n, output bit prime);
    int unsigned t;
    t = 1;
    prime = 1'b0;
    for (int unsigned d = 2; d <= 65536; d++) begin
      t++;
      if (d == n) begin prime = 1'b1; break; end
      if (n < d) break;
      t++;
      if (n % d == 0) begin t += n / d; break; end
      t += n / d + 2;
    end
    return t + 1;
  endfunction

  task automatic set_start(input int inst, input logic v);
    if (inst == 0) start_a = v;
    else           start_b = v;
  endtask

  task automatic run(input int inst, input int unsigned n, input bit mid_start);
    int unsigned b, bp, mx, k, bad;
    bit prime, exp_err, exp_res;
    b  = ref_busy(n, prime);
    mx = (inst == 0) ? MAXA : MAXB;
    exp_err = (mx <= b - 1);
    bp      = exp_err ? mx + 2 : b;
    exp_res = exp_err ? 1'b0 : prime;
    if (inst == 0) n_a = 16'(n);
    else           n_b = 16'(n);
    @(negedge clk);
    set_start(inst, 1'b1);
    @(negedge clk);
    set_start(inst, 1'b0);
    k = 1;
    bad = 0;
    while (!done_v[inst] && k < 3000) begin
      if (!busy_v[inst]) bad++;
      if (nbuf_v[inst] && rembuf_v[inst]) bad++;
      set_start(inst, mid_start && k == 4);
      @(negedge clk);
      k++;
    end
    set_start(inst, 1'b0);
    chk($sformatf("done_time[%0d] n=%0d", inst, n), k, bp + 1);
    chk($sformatf("busy_run[%0d] n=%0d", inst, n), bad, 0);
    chk($sformatf("res[%0d] n=%0d", inst, n), res_v[inst], exp_res);
    chk($sformatf("err[%0d] n=%0d", inst, n), err_v[inst], exp_err);
    chk($sformatf("busy_done[%0d] n=%0d", inst, n), busy_v[inst], 0);
`ifdef DIVTEST_CYCCNT_EN
    chk($sformatf("cycles[%0d] n=%0d", inst, n), (inst == 0) ? cyc_a : cyc_b, bp);
`endif
    @(negedge clk);
    chk($sformatf("done_once[%0d] n=%0d", inst, n), done_v[inst], 0);
    chk($sformatf("idle_busy[%0d] n=%0d", inst, n), busy_v[inst], 0);
    chk($sformatf("err_hold[%0d] n=%0d", inst, n), err_v[inst], exp_err);
  endtask

  logic [33:0] outs;
  assign outs = {remld_a, divld_a, resld_a, nbuf_a, rembuf_a, zc_a, sc_a, busy_a, done_a, err_a,
                 remld_b, divld_b, resld_b, nbuf_b, rembuf_b, zc_b, sc_b, busy_b, done_b, err_b, 10'd0};

  initial begin
    #2;
    chk("reset_outs", outs, 0);
`ifdef DIVTEST_CYCCNT_EN
    chk("reset_cycles", {cyc_a, cyc_b}, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run(0, 2, 0);
    run(0, 9, 0);
    run(0, 7, 0);
    run(0, 1, 0);
    run(0, 0, 0);
    run(0, 7, 1);
    run(1, 7, 0);
    run(1, 2, 0);
    run(1, 3, 0);
    run(1, 10, 0);

    // Reset in the middle of a run, then rerun the same n.
    n_a = 16'd7;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 50 && !rembuf_a; i++) @(negedge clk);
    chk("reach_sub", rembuf_a, 1);
    #2 rst = 1'b1;
    #1 chk("rst_mid_outs", outs, 0);
    @(negedge clk);
    chk("rst_hold_outs", outs, 0);
    rst = 1'b0;
    run(0, 7, 0);

    for (int i = 0; i < 16; i++) begin
      run(i % 2, $urandom_range(0, 40), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
